// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Sequencer for a ring-oscillator PUF. A 16-bit challenge seeds a Galois
//   LFSR. Each LFSR state picks one oscillator pair. For each pair the block
//   clears the counters, enables the oscillators for a timed window, lets the
//   counters settle and then compares them. The comparison bits are packed
//   into the response word.
//
//   Build option: PUF_MAJORITY_VOTE_EN. When it is defined, each pair is
//   measured three times and the response bit is the majority of the three
//   results.
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous reset, active-high
//     start      run request, sampled only in IDLE
//     challenge  challenge word, latched when start is accepted
//     busy       run in progress (CLEAR..COMPARE)
//     done       one-cycle pulse when response/tie_seen update
//     response   last completed response
//     tie_seen   at least one compare in the last run had cnt_a == cnt_b
//     ro_en      oscillator enable for the selected pair
//     ro_clr     synchronous clear for both counters
//     sel_a      ring oscillator index for counter A
//     sel_b      ring oscillator index for counter B
//     cnt_a      counter A value
//     cnt_b      counter B value
//
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | latch pair selection, clear counters
//   MEASURE | ro_en high for WIN_CYC cycles
//   SETTLE  | ro_en low, counters settle for SETTLE_CYC cycles
//   COMPARE | sample cnt_a > cnt_b into the shadow word
//   DONE    | publish response, pulse done
module puf_challenge_sequencer #(
  parameter int RESP_BITS  = 8,
  parameter int CNT_W      = 32,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          challenge,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie_seen,
  output logic                 ro_en,
  output logic                 ro_clr,
  output logic [4:0]           sel_a,
  output logic [4:0]           sel_b,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] MEASURE = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] COMPARE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  logic [2:0]           state;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_adv;
  logic [TMR_W-1:0]     tmr;
  logic [IDX_W-1:0]     idx;
  logic [RESP_BITS-1:0] shadow;
  logic [RESP_BITS-1:0] shadow_nxt;
  logic                 shadow_tie;
  logic                 tie_nxt;
  logic                 cmp_bit;
  logic                 cmp_tie;
  logic                 bit_val;
  logic                 bit_final;
  logic                 last_bit;

  assign cmp_bit  = (cnt_a > cnt_b);
  assign cmp_tie  = (cnt_a == cnt_b);
  assign tie_nxt  = shadow_tie | cmp_tie;
  assign last_bit = (idx == IDX_W'(RESP_BITS - 1));
  // Galois LFSR with polynomial 0xB400. It shifts right and feeds back from bit 0.
  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] rep;
  logic [1:0] votes;
  // The 2-bit sum cannot overflow: after two compares votes is at most 2.
  assign bit_final = (rep == 2'd2);
  assign bit_val   = ((votes + {1'b0, cmp_bit}) >= 2'd2);
`else
  assign bit_final = 1'b1;
  assign bit_val   = cmp_bit;
`endif

  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[idx] = bit_val;
  end

  // Outputs decode from state, so the async reset drops ro_en and busy immediately.
  assign busy   = (state == CLEAR) || (state == MEASURE) ||
                  (state == SETTLE) || (state == COMPARE);
  assign done   = (state == DONE);
  assign ro_en  = (state == MEASURE);
  assign ro_clr = (state == CLEAR);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      lfsr       <= 16'h0000;
      tmr        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_tie <= 1'b0;
      response   <= '0;
      tie_seen   <= 1'b0;
      sel_a      <= 5'd0;
      sel_b      <= 5'd0;
`ifdef PUF_MAJORITY_VOTE_EN
      rep        <= 2'd0;
      votes      <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // A zero seed would lock up the LFSR, so it is replaced by 0xACE1.
            lfsr       <= (challenge == 16'h0000) ? 16'hACE1 : challenge;
            idx        <= '0;
            shadow     <= '0;
            shadow_tie <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            rep        <= 2'd0;
            votes      <= 2'd0;
`endif
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          sel_a <= lfsr[4:0];
          // Comparing an oscillator with itself tells nothing, so force distinct indices.
          sel_b <= (lfsr[9:5] == lfsr[4:0]) ? (lfsr[9:5] ^ 5'd1) : lfsr[9:5];
          tmr   <= TMR_W'(WIN_CYC - 1);
          state <= MEASURE;
        end
        MEASURE: begin
          if (tmr == '0) begin
            tmr   <= TMR_W'(SETTLE_CYC - 1);
            state <= SETTLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == '0) state <= COMPARE;
          else           tmr   <= tmr - 1'b1;
        end
        COMPARE: begin
          shadow_tie <= tie_nxt;
          if (bit_final) begin
            shadow <= shadow_nxt;
            lfsr   <= lfsr_adv;
            if (last_bit) begin
              response <= shadow_nxt;
              tie_seen <= tie_nxt;
              state    <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= CLEAR;
            end
          end else begin
            state <= CLEAR;
          end
`ifdef PUF_MAJORITY_VOTE_EN
          rep   <= bit_final ? 2'd0 : rep + 2'd1;
          votes <= bit_final ? 2'd0 : votes + {1'b0, cmp_bit};
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  localparam int RESP_BITS  = 8;
  localparam int CNT_W      = 32;
  localparam int WIN_CYC    = 16;
  localparam int SETTLE_CYC = 4;
  localparam int L          = WIN_CYC + SETTLE_CYC + 2;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int REP = 3;
`else
  localparam int REP = 1;
`endif
  localparam int EXP_LAT = RESP_BITS * L * REP;
  localparam int BUDGET  = EXP_LAT + 200;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [15:0]          challenge;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic                 tie_seen;
  logic                 ro_en;
  logic                 ro_clr;
  logic [4:0]           sel_a;
  logic [4:0]           sel_b;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;

  int checks = 0;
  int errors = 0;
  bit tie_mode = 0;

  int exp_a [RESP_BITS];
  int exp_b [RESP_BITS];
  logic [RESP_BITS-1:0] exp_resp;
  int q_sel_a[$];
  int q_sel_b[$];
  int q_en_len[$];
  bit busy_first;
  bit busy_at_done;

  puf_challenge_sequencer #(
    .RESP_BITS(RESP_BITS), .CNT_W(CNT_W), .WIN_CYC(WIN_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .busy(busy), .done(done), .response(response), .tie_seen(tie_seen),
    .ro_en(ro_en), .ro_clr(ro_clr), .sel_a(sel_a), .sel_b(sel_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The counters count while ro_en is high and hold their value while it is low.
  // While counting they read 100 plus the selected oscillator index.
  always @(posedge clk) begin
    if (tie_mode) begin
      cnt_a <= 32'd50;
      cnt_b <= 32'd50;
    end else if (ro_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (ro_en) begin
      cnt_a <= 32'd100 + {27'd0, sel_a};
      cnt_b <= 32'd100 + {27'd0, sel_b};
    end
  end

  // Reference model: computes the selection sequence and the response from
  // the challenge, the LFSR rule and the counter model above.
  function automatic void model(input logic [15:0] ch);
    int s;
    int a;
    int b;
    s = (ch == 16'h0000) ? 16'hACE1 : int'(ch);
    exp_resp = '0;
    for (int i = 0; i < RESP_BITS; i++) begin
      a = s % 32;
      b = (s / 32) % 32;
      if (a == b) b = b ^ 1;
      exp_a[i] = a;
      exp_b[i] = b;
      exp_resp[i] = ((100 + a) > (100 + b));
      if (s % 2 == 1) s = (s / 2) ^ 16'hB400;
      else            s = s / 2;
    end
  endfunction

  // Call this at the negedge of the first cycle after the acceptance edge.
  // That negedge is cycle 0.
  task automatic wait_done(output int lat);
    bit prev_en;
    int len;
    lat = -1;
    prev_en = 0;
    len = 0;
    q_sel_a.delete();
    q_sel_b.delete();
    q_en_len.delete();
    busy_first = busy;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ro_en) begin
        if (!prev_en) begin
          q_sel_a.push_back(int'(sel_a));
          q_sel_b.push_back(int'(sel_b));
        end
        len++;
      end else if (prev_en) begin
        q_en_len.push_back(len);
        len = 0;
      end
      prev_en = ro_en;
      if (done) begin
        lat = cyc;
        busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic do_run(input logic [15:0] ch, output int lat);
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_run(input string tag, input logic [15:0] ch, input int lat);
    checks++;
    if (lat !== EXP_LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, EXP_LAT);
    end
    checks++;
    if (response !== exp_resp) begin
      errors++;
      $display("FAIL %s response ch=%h: got %h expected %h", tag, ch, response, exp_resp);
    end
  endtask

  task automatic test_reset;
    int en_hits;
    rst_n = 1'b1;
    start = 1'b0;
    challenge = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ro_en, ro_clr, tie_seen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, ro_en, ro_clr, tie_seen});
    end
    checks++;
    if (response !== '0) begin
      errors++;
      $display("FAIL reset_response: got %h expected 0", response);
    end
    checks++;
    if ({sel_a, sel_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_sel: got %0d/%0d expected 0/0", sel_a, sel_b);
    end
    rst_n = 1'b0;
    en_hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (ro_en || busy) en_hits++;
    end
    checks++;
    if (en_hits !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", en_hits);
    end
  endtask

  task automatic test_basic;
    int lat;
    model(16'h0001);
    do_run(16'h0001, lat);
    check_run("basic", 16'h0001, lat);
    checks++;
    if (busy_first !== 1'b1) begin
      errors++;
      $display("FAIL busy_next_cycle: got %b expected 1", busy_first);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b expected 0", busy_at_done);
    end
    checks++;
    if (tie_seen !== 1'b0) begin
      errors++;
      $display("FAIL basic_tie: got %b expected 0", tie_seen);
    end
    checks++;
    if (q_en_len.size() !== RESP_BITS * REP) begin
      errors++;
      $display("FAIL en_pulses: got %0d expected %0d", q_en_len.size(), RESP_BITS * REP);
    end
    for (int i = 0; i < q_en_len.size() && i < RESP_BITS * REP; i++) begin
      checks++;
      if (q_en_len[i] !== WIN_CYC) begin
        errors++;
        $display("FAIL en_width[%0d]: got %0d expected %0d", i, q_en_len[i], WIN_CYC);
      end
      checks++;
      if (q_sel_a[i] !== exp_a[i / REP] || q_sel_b[i] !== exp_b[i / REP]) begin
        errors++;
        $display("FAIL sel[%0d]: got %0d/%0d expected %0d/%0d", i, q_sel_a[i], q_sel_b[i],
                 exp_a[i / REP], exp_b[i / REP]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (response !== exp_resp) begin
      errors++;
      $display("FAIL response_hold: got %h expected %h", response, exp_resp);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [15:0] ch;
    for (int k = 0; k < 4; k++) begin
      ch = 16'($urandom_range(1, 16'hFFFF));
      model(ch);
      do_run(ch, lat);
      check_run("random", ch, lat);
    end
  endtask

  task automatic test_tie;
    int lat;
    logic [15:0] ch;
    tie_mode = 1;
    ch = 16'($urandom);
    do_run(ch, lat);
    checks++;
    if (response !== '0 || tie_seen !== 1'b1) begin
      errors++;
      $display("FAIL tie_run: got resp=%h tie=%b expected resp=00 tie=1", response, tie_seen);
    end
    tie_mode = 0;
    ch = 16'($urandom_range(1, 16'hFFFF));
    model(ch);
    do_run(ch, lat);
    check_run("after_tie", ch, lat);
    checks++;
    if (tie_seen !== 1'b0) begin
      errors++;
      $display("FAIL tie_cleared: got %b expected 0", tie_seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] c1;
    logic [15:0] c2;
    c1 = 16'($urandom_range(1, 16'hFFFF));
    c2 = 16'($urandom_range(1, 16'hFFFF));
    @(negedge clk);
    challenge = c1;
    start = 1'b1;
    @(negedge clk);
    // start stays high and challenge changes for the whole run; neither may disturb the run.
    challenge = 16'($urandom);
    model(c1);
    wait_done(lat);
    check_run("held_start_run1", c1, lat);
    challenge = c2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy got %b expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ro_clr !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy/ro_clr got %b/%b expected 1/1", busy, ro_clr);
    end
    start = 1'b0;
    model(c2);
    wait_done(lat);
    check_run("b2b_run2", c2, lat);
  endtask

  task automatic test_reset_midrun;
    int lat;
    int guard;
    int done_hits;
    logic [15:0] ch;
    ch = 16'h0001;
    for (int k = 0; k < 50; k++) begin
      ch = 16'($urandom_range(1, 16'hFFFF));
      model(ch);
      if (exp_resp != '0) break;
    end
    do_run(ch, lat);
    check_run("pre_abort", ch, lat);
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!ro_en && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (ro_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_measure: ro_en got %b expected 1", ro_en);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (ro_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: ro_en/busy got %b/%b expected 0/0", ro_en, busy);
    end
    checks++;
    if (response !== '0) begin
      errors++;
      $display("FAIL abort_response: got %h expected 0", response);
    end
    @(negedge clk);
    rst_n = 1'b0;
    done_hits = 0;
    repeat (EXP_LAT + 20) begin
      @(negedge clk);
      if (done || busy) done_hits++;
    end
    checks++;
    if (done_hits !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", done_hits);
    end
  endtask

  task automatic test_zero_seed;
    int lat;
    int sa0[$];
    int sb0[$];
    logic [RESP_BITS-1:0] r0;
    model(16'h0000);
    do_run(16'h0000, lat);
    check_run("seed_zero", 16'h0000, lat);
    r0 = response;
    sa0 = q_sel_a;
    sb0 = q_sel_b;
    do_run(16'hACE1, lat);
    checks++;
    if (response !== r0) begin
      errors++;
      $display("FAIL seed_equiv_resp: got %h expected %h", response, r0);
    end
    checks++;
    if (q_sel_a != sa0 || q_sel_b != sb0) begin
      errors++;
      $display("FAIL seed_equiv_sel: sequences differ (%0d vs %0d entries)", q_sel_a.size(), sa0.size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    challenge = 16'h0;
    test_reset();
    test_basic();
    test_random();
    test_tie();
    test_back_to_back();
    test_reset_midrun();
    test_zero_seed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
